// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with an inter-frame idle gap and a sticky watchdog on the transmitter's done pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_send,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    input  logic                       err_clr
);
    localparam int IDW     = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_e;

    // With no gap configured the frame end returns straight to arbitration.
    localparam state_e          POST_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;
    localparam logic [CW-1:0]   TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [IDW-1:0]  LAST_IDX   = IDW'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [IDW-1:0]      gid_q, gid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q;
    logic                err_q, err_d;
    logic                to_hit;

    logic                sel_found;
    logic [IDW-1:0]      sel_idx;
    logic [IDW-1:0]      scan_idx;
    logic [DATA_W-1:0]   sel_data;

    // Scan starts just after the last winner so every other valid source goes first.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = rr_q;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            if (!sel_found && req_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDW'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign to_hit = (state_q == WAIT_DONE) && !tx_done && (cnt_q == TO_LAST);
    assign err_d  = to_hit | (err_q & ~err_clr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = LOAD;
                    rr_d    = sel_idx;
                    gid_d   = sel_idx;
                    data_d  = sel_data;
                end
            end
            LOAD: begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                // tx_done takes priority over an expiring watchdog in the same cycle.
                if (tx_done || cnt_q == TO_LAST) begin
                    state_d = POST_STATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_send   = 1'b0;
        req_ready = '0;
        if (state_q == LOAD) begin
            tx_send          = 1'b1;
            req_ready[gid_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= LAST_IDX;
            gid_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            busy_q  <= (state_d != IDLE);
            err_q   <= err_d;
        end
    end

    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule
